mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous block RAM between the instruction-fetch port and the load/store data port. This lets the processor run from a unified instruction/data memory instead of two separate RAM instances.
- Grants at most one access per cycle and returns read data with fixed latency.
- Raises a stall to the PC/branch logic whenever a request is pending but not granted.
- Bounded-starvation data-priority arbitration.

Parameters:
ADDR_W, 32, address width of both requesters and the memory.
DATA_W, 32, data word width.
STREAK_MAX, 4, maximum consecutive data grants while a fetch waits; range 1..15.
READ_LAT, 1, RAM read latency in cycles (1 or 2).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
if_req  in  1  fetch request; held until if_gnt.
if_addr  in  ADDR_W  fetch word address.
if_gnt  out  1  fetch accepted this cycle.
if_rvalid  out  1  if_rdata valid.
if_rdata  out  DATA_W  fetched instruction.
d_req  in  1  data request; held until d_gnt.
d_we  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  data word address.
d_wdata  in  DATA_W  store data.
d_gnt  out  1  data access accepted this cycle; for a store, the write is performed this cycle.
d_rvalid  out  1  d_rdata valid.
d_rdata  out  DATA_W  load data.
mem_en  out  1  RAM enable.
mem_we  out  1  RAM write enable.
mem_addr  out  ADDR_W  RAM address.
mem_din  out  DATA_W  RAM write data.
mem_dout  in  DATA_W  RAM read data, READ_LAT cycles after mem_en with mem_we=0.
stall  out  1  (if_req & ~if_gnt) | (d_req & ~d_gnt).

Behaviour:
- Reset (reset=0, asynchronous):
  - streak counter = 0; return pipeline cleared.
  - if_rvalid = d_rvalid = 0.
  - if_gnt, d_gnt, mem_en and mem_we are forced to 0 while reset is low.
  - Reads in flight when reset asserts are dropped and never produce rvalid.
- Grant (combinational from requests and registered state, same cycle as the request):
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both, streak < STREAK_MAX: grant data.
  - Both, streak == STREAK_MAX: grant fetch.
  - Neither: mem_en = 0, no grant.
- Memory drive on grant:
  - mem_en = 1; mem_addr = address of the granted requester.
  - Data grant: mem_we = d_we, mem_din = d_wdata.
  - Fetch grant: mem_we = 0, mem_din = 0.
  - Without a grant, mem_addr, mem_din and mem_we are 0.
- Streak counter (4-bit register):
  - Increments on a data grant while if_req=1; saturates at STREAK_MAX.
  - Clears to 0 on any fetch grant, or on any cycle with if_req=0.
- Return pipeline:
  - READ_LAT-deep shift register of {valid, source}.
  - Stage 0 is loaded on every read grant (fetch, or data with d_we=0).
  - Stores and idle cycles insert a bubble.
  - When the last stage is valid, the matching rvalid is 1 for exactly one cycle. The other rvalid stays 0.
- Read data paths:
  - if_rdata and d_rdata are driven directly from mem_dout.
  - Each is meaningful only while its rvalid is high.
- Back-to-back issue:
  - Fully pipelined: a new grant may occur every cycle, independent of outstanding reads.
  - Read responses return in grant order.
- Ordering and hazards:
  - A store followed by a load to the same address in the next cycle returns the stored value; the RAM is write-first per cycle order.
  - Requests must stay stable while req=1 and gnt=0. If a requester drops req before gnt, nothing is issued.
- Simultaneous events: when a request and a response return land in the same cycle, both are honoured. Grant and rvalid are independent.
- stall is purely combinational and is 0 during reset.

Test Plan:
- Reset check: hold reset=0 with if_req=1 and d_req=1 -> all gnt, rvalid, mem_en and stall are 0. Release reset -> d_gnt=1 in the first cycle.
- Single fetch, READ_LAT=1, RAM word 5 = 0x8C220004: if_req=1, if_addr=5 -> if_gnt=1, mem_en=1, mem_addr=5 that cycle. Next cycle if_rvalid=1 and if_rdata=0x8C220004; d_rvalid stays 0.
- Store then load: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, granted; then d_we=0, d_addr=0x10 -> load granted the next cycle. d_rvalid=1 one cycle later with d_rdata=0xDEADBEEF. No rvalid follows the store.
- Starvation bound, STREAK_MAX=4: if_req and d_req held high continuously -> grant sequence is D,D,D,D,F,D,D,D,D,F... stall=1 in every cycle.
- Pipelined mix, READ_LAT=2: alternating fetch/load grants on cycles 1-4 -> rvalids on cycles 3-6, matching source and address order. No gaps, no duplicates.
- Reset mid-flight: read granted at cycle N, reset low at N+0.5 cycle -> no rvalid at N+READ_LAT. After reset release, the streak counter restarts from 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous RAM between the instruction-fetch
//   port and the load/store data port. At most one access is granted per
//   cycle. Data normally wins; a streak counter bounds how many data grants
//   in a row may pass a waiting fetch. Read data comes back straight from the
//   RAM after READ_LAT cycles, tagged with a valid for the requester that
//   issued the read.
//
// Ports
//   clk, reset            clock (rising edge), async active-low reset
//   if_req/if_addr        fetch request (held until if_gnt)
//   if_gnt                fetch accepted this cycle
//   if_rvalid/if_rdata    fetch read response
//   d_req/d_we/d_addr/d_wdata  data request (held until d_gnt)
//   d_gnt                 data access accepted (stores write this cycle)
//   d_rvalid/d_rdata      load read response
//   mem_en/mem_we/mem_addr/mem_din/mem_dout  RAM port
//   stall                 some request is pending but not granted
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STREAK_MAX = 4,
    parameter int READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              stall
);

    localparam logic [3:0] SMAX = 4'(STREAK_MAX);

    logic [3:0]          r_streak;
    logic [READ_LAT-1:0] r_vld_pipe;   // read in flight at each stage
    logic [READ_LAT-1:0] r_src_pipe;   // 1 = data load, 0 = fetch

    logic w_gnt_d;
    logic w_gnt_f;
    logic w_rd;

    // Data wins unless a fetch is waiting and the streak is used up.
    // Both grants are held low during reset.
    assign w_gnt_d = reset & d_req & (~if_req | (r_streak < SMAX));
    assign w_gnt_f = reset & if_req & ~w_gnt_d;
    assign w_rd    = w_gnt_f | (w_gnt_d & ~d_we);

    assign if_gnt = w_gnt_f;
    assign d_gnt  = w_gnt_d;
    assign stall  = reset & ((if_req & ~w_gnt_f) | (d_req & ~w_gnt_d));

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (w_gnt_d) begin
            mem_en   = 1'b1;
            mem_we   = d_we;
            mem_addr = d_addr;
            mem_din  = d_wdata;
        end else if (w_gnt_f) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    // Counts data grants that passed a waiting fetch; any cycle without a
    // fetch waiting, or a fetch grant, starts the count over.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_streak <= 4'd0;
        end else if (!if_req || w_gnt_f) begin
            r_streak <= 4'd0;
        end else if (w_gnt_d && (r_streak < SMAX)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    // Response tag pipeline; reset drops anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_pipe <= '0;
            r_src_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_rd;
            r_src_pipe[0] <= w_gnt_d;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_src_pipe[i] <= r_src_pipe[i-1];
            end
        end
    end

    assign if_rvalid = r_vld_pipe[READ_LAT-1] & ~r_src_pipe[READ_LAT-1];
    assign d_rvalid  = r_vld_pipe[READ_LAT-1] &  r_src_pipe[READ_LAT-1];
    assign if_rdata  = mem_dout;
    assign d_rdata   = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (READ_LAT=1 and READ_LAT=2)
// share one stimulus stream, each with its own RAM model. Expected grants,
// memory drive, stall and read responses come from a reference model built
// on the arbitration rules, a shadow memory and a queue of pending replies.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    typedef struct {
        int          due;
        bit          src;   // 1 = data load
        logic [31:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;

    logic          if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, stall1;
    logic [DW-1:0] if_rdata1, d_rdata1, mem_din1, mem_dout1;
    logic [AW-1:0] mem_addr1;
    logic          if_gnt2, if_rvalid2, d_gnt2, d_rvalid2, mem_en2, mem_we2, stall2;
    logic [DW-1:0] if_rdata2, d_rdata2, mem_din2, mem_dout2;
    logic [AW-1:0] mem_addr2;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(SMAX), .READ_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_din(mem_din1), .mem_dout(mem_dout1), .stall(stall1)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(SMAX), .READ_LAT(2)) dut2 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt2),
        .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_din(mem_din2), .mem_dout(mem_dout2), .stall(stall2)
    );

    // RAM models, 32 words (the bench only uses addresses 0..31)
    logic [31:0] ram1 [32];
    logic [31:0] ram2 [32];
    logic [31:0] ram2_s1;

    always @(posedge clk) begin
        if (mem_en1) begin
            if (mem_we1) ram1[mem_addr1[4:0]] <= mem_din1;
            else         mem_dout1 <= ram1[mem_addr1[4:0]];
        end
    end

    always @(posedge clk) begin
        if (mem_en2) begin
            if (mem_we2) ram2[mem_addr2[4:0]] <= mem_din2;
            else         ram2_s1 <= ram2[mem_addr2[4:0]];
        end
        mem_dout2 <= ram2_s1;
    end

    // reference model state
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          m_streak = 0;   // data grants in a row while a fetch waits
    logic [31:0] shadow [32];
    rsp_t        q1[$];
    rsp_t        q2[$];
    bit          last_gf, last_gd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, got, exp);
        end
    endtask

    task automatic gnt_chk(input string n, input logic ig, dg, en, we,
                           input logic [31:0] addr, din, input logic st,
                           input bit egf, egd, ewe, input logic [31:0] eaddr, edin,
                           input bit est);
        chk({n, "if_gnt"},   ig,   egf);
        chk({n, "d_gnt"},    dg,   egd);
        chk({n, "mem_en"},   en,   egf | egd);
        chk({n, "mem_we"},   we,   ewe);
        chk({n, "mem_addr"}, addr, eaddr);
        chk({n, "mem_din"},  din,  edin);
        chk({n, "stall"},    st,   est);
    endtask

    task automatic rsp_chk(input string n, input bit hv, input rsp_t h,
                           input logic iv, input logic [31:0] idat,
                           input logic dv, input logic [31:0] ddat);
        bit ei, ed;
        ei = hv && (h.due == cyc) && !h.src;
        ed = hv && (h.due == cyc) &&  h.src;
        chk({n, "if_rvalid"}, iv, ei);
        chk({n, "d_rvalid"},  dv, ed);
        if (ei) chk({n, "if_rdata"}, idat, h.data);
        if (ed) chk({n, "d_rdata"},  ddat, h.data);
    endtask

    // One clock: drive inputs at the falling edge, check 1 time unit later,
    // then advance the model.
    task automatic tick(input bit rs, input bit fr, input logic [7:0] fa,
                        input bit dr, input bit dw, input logic [7:0] da,
                        input logic [31:0] dwd);
        bit gf, gd, st, hv;
        logic [31:0] eaddr, edin;
        rsp_t h, rd;
        @(negedge clk);
        reset   = rs;
        if_req  = fr;
        if_addr = {24'b0, fa};
        d_req   = dr;
        d_we    = dw;
        d_addr  = {24'b0, da};
        d_wdata = dwd;
        #1;
        cyc++;
        if (!rs) begin
            gf = 1'b0; gd = 1'b0; st = 1'b0;
            m_streak = 0;
            q1.delete(); q2.delete();
        end else begin
            gd = dr && (!fr || m_streak < SMAX);
            gf = fr && !gd;
            st = (fr && !gf) || (dr && !gd);
        end
        eaddr = gf ? {24'b0, fa} : (gd ? {24'b0, da} : 32'd0);
        edin  = gd ? dwd : 32'd0;
        gnt_chk("A.", if_gnt1, d_gnt1, mem_en1, mem_we1, mem_addr1, mem_din1, stall1,
                gf, gd, gd && dw, eaddr, edin, st);
        gnt_chk("B.", if_gnt2, d_gnt2, mem_en2, mem_we2, mem_addr2, mem_din2, stall2,
                gf, gd, gd && dw, eaddr, edin, st);

        h = '{due: 0, src: 1'b0, data: 32'd0};
        hv = q1.size() > 0;
        if (hv) h = q1[0];
        rsp_chk("A.", hv, h, if_rvalid1, if_rdata1, d_rvalid1, d_rdata1);
        if (hv && h.due == cyc) void'(q1.pop_front());
        h = '{due: 0, src: 1'b0, data: 32'd0};
        hv = q2.size() > 0;
        if (hv) h = q2[0];
        rsp_chk("B.", hv, h, if_rvalid2, if_rdata2, d_rvalid2, d_rdata2);
        if (hv && h.due == cyc) void'(q2.pop_front());

        if (gf || (gd && !dw)) begin
            rd.src  = gd;
            rd.data = shadow[gf ? fa[4:0] : da[4:0]];
            rd.due  = cyc + 1; q1.push_back(rd);
            rd.due  = cyc + 2; q2.push_back(rd);
        end
        if (gd && dw) shadow[da[4:0]] = dwd;
        if (rs) begin
            if (!fr || gf)                 m_streak = 0;
            else if (gd && m_streak < SMAX) m_streak++;
        end
        last_gf = gf;
        last_gd = gd;
    endtask

    initial begin
        int i, k;
        bit fr, dr, dw, fp, dp;
        logic [7:0] fa, da;
        logic [31:0] dwd;

        // reset held with both requesting: nothing granted, no stall
        repeat (3) tick(0, 1, 8'd3, 1, 0, 8'd4, 32'd0);

        // release; preload RAM with stores while fetches of word 0 compete
        i = 0; k = 0;
        while (i < 32) begin
            dwd = (i == 5) ? 32'h8C220004 : $urandom;
            tick(1, k < 12, 8'd0, 1, 1, 8'(i), dwd);
            if (last_gd) i++;
            k++;
        end
        tick(1, 0, 8'd0, 0, 0, 8'd0, 32'd0);
        tick(1, 0, 8'd0, 0, 0, 8'd0, 32'd0);

        // single fetch of word 5
        tick(1, 1, 8'd5, 0, 0, 8'd0, 32'd0);
        repeat (2) tick(1, 0, 8'd0, 0, 0, 8'd0, 32'd0);

        // store then load, same address
        tick(1, 0, 8'd0, 1, 1, 8'h10, 32'hDEADBEEF);
        tick(1, 0, 8'd0, 1, 0, 8'h10, 32'd0);
        repeat (3) tick(1, 0, 8'd0, 0, 0, 8'd0, 32'd0);

        // back-to-back alternating fetch / load
        tick(1, 1, 8'd1, 0, 0, 8'd0, 32'd0);
        tick(1, 0, 8'd0, 1, 0, 8'd2, 32'd0);
        tick(1, 1, 8'd3, 0, 0, 8'd0, 32'd0);
        tick(1, 0, 8'd0, 1, 0, 8'd16, 32'd0);
        repeat (3) tick(1, 0, 8'd0, 0, 0, 8'd0, 32'd0);

        // streak partly built, then a read granted and reset mid-cycle
        tick(1, 1, 8'd9, 1, 0, 8'd6, 32'd0);
        tick(1, 1, 8'd9, 1, 0, 8'd7, 32'd0);
        tick(1, 1, 8'd7, 0, 0, 8'd0, 32'd0);
        #1;
        reset = 1'b0;
        m_streak = 0;
        q1.delete(); q2.delete();
        repeat (3) tick(0, 0, 8'd0, 0, 0, 8'd0, 32'd0);
        // streak restarts from zero: four loads pass the fetch, then it goes
        for (int j = 0; j < 7; j++) tick(1, 1, 8'd11, 1, 0, 8'(j), 32'd0);
        repeat (3) tick(1, 0, 8'd0, 0, 0, 8'd0, 32'd0);

        // randomized traffic obeying the hold-until-grant rule
        fp = 0; dp = 0;
        fr = 0; dr = 0; dw = 0; fa = 0; da = 0; dwd = 0;
        repeat (400) begin
            if (!fp) begin
                fr = $urandom_range(0, 2) != 0;
                fa = 8'($urandom_range(0, 31));
            end
            if (!dp) begin
                dr  = $urandom_range(0, 2) != 0;
                dw  = $urandom_range(0, 1) != 0;
                da  = 8'($urandom_range(0, 31));
                dwd = $urandom;
            end
            tick(1, fr, fa, dr, dw, da, dwd);
            fp = fr && !last_gf;
            dp = dr && !last_gd;
        end
        repeat (3) tick(1, 0, 8'd0, 0, 0, 8'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
